// File: rtl/area_bin_pkg.sv
// rtl/area_bin_pkg.sv - shared types and constants for the area binarization controller
// Contents: FSM state encoding, default pipeline latency, default coordinate
// width and the foreground-count width.
package area_bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int PIPE_LAT_DEF = 4;
  localparam int DIM_W_DEF    = 12;
  localparam int FG_W         = 24;

endpackage

// File: rtl/area_bin_coord_cnt.sv
// rtl/area_bin_coord_cnt.sv - saturating x/y window coordinate counters
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   clr_i            synchronous clear of both counters (frame start)
//   de_i             window data enable
//   x_o, y_o         coordinate of the window currently presented on de_i
module area_bin_coord_cnt
  import area_bin_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             de_i,
  output logic [DIM_W-1:0] x_o,
  output logic [DIM_W-1:0] y_o
);

  localparam logic [DIM_W-1:0] MAX_VAL = '1;

  logic             de_q;
  logic [DIM_W-1:0] x_q, x_d;
  logic [DIM_W-1:0] y_q, y_d;

  // x counts pixels within the line, y counts completed lines (advanced on
  // the falling edge of de). Both stick at all-ones so overlong lines or
  // frames stay inside the masked border instead of wrapping to zero.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (de_i) begin
      if (x_q != MAX_VAL) x_d = x_q + 1'b1;
    end else if (de_q) begin
      x_d = '0;
      if (y_q != MAX_VAL) y_d = y_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      de_q <= de_i;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/area_bin_ctrl.sv
// rtl/area_bin_ctrl.sv - frame-synchronous config, border mask and output stage for binarization
// Optional feature macro: AREA_BIN_STAT_EN (foreground pixel counter on fg_count).
// Ports:
//   video_clk, rst_n                       clock, asynchronous active-low reset
//   cfg_wr/en/offset/width/height          shadowed configuration write
//   matrix_vs, matrix_de                   3x3 window timing
//   bin_vs, bin_de, bin_data               datapath result, PIPE_LAT after matrix_de
//   ctrl_en, ctrl_offset                   frame-stable config to the datapath
//   out_vs, out_de, out_data               registered, border-masked result
//   cfg_ack, frame_done, busy, frame_err   status
//   fg_count                               foreground count of last completed frame
module area_bin_ctrl
  import area_bin_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int DIM_W    = DIM_W_DEF
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic             cfg_en,
  input  logic [7:0]       cfg_offset,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             matrix_vs,
  input  logic             matrix_de,
  input  logic             bin_vs,
  input  logic             bin_de,
  input  logic             bin_data,
  output logic             ctrl_en,
  output logic [7:0]       ctrl_offset,
  output logic             out_vs,
  output logic             out_de,
  output logic             out_data,
  output logic             cfg_ack,
  output logic             frame_done,
  output logic             busy,
  output logic             frame_err,
  output logic [FG_W-1:0]  fg_count
);

  localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);

  logic             vs_q;
  logic             vs_rise;
  logic             apply;
  logic             err_set;
  logic             pend_q;
  logic             sh_en_q;
  logic [7:0]       sh_off_q;
  logic [DIM_W-1:0] sh_w_q, sh_h_q;
  logic             en_q;
  logic [7:0]       off_q;
  logic [DIM_W-1:0] w_q, h_q;
  logic             ack_q;
  logic             err_q;
  state_e           state_q, state_d;
  logic             busy_c, done_c;
  logic [DIM_W-1:0] x, y;
  logic             last_px;
  logic             mask;
  logic [PIPE_LAT-1:0] mask_pipe_q;
  logic             mask_dly;
  logic             out_vs_q, out_de_q, out_data_q;

  assign vs_rise = matrix_vs & ~vs_q;
  // A write landing on the frame edge only refreshes the shadow; it waits
  // for the following frame so the datapath never sees a half-applied set.
  assign apply   = vs_rise & pend_q & ~cfg_wr;
  assign err_set = (state_q == ST_ACTIVE) & vs_rise;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      pend_q   <= 1'b0;
      sh_en_q  <= 1'b0;
      sh_off_q <= '0;
      sh_w_q   <= '0;
      sh_h_q   <= '0;
      en_q     <= 1'b0;
      off_q    <= '0;
      w_q      <= '0;
      h_q      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vs_q  <= matrix_vs;
      ack_q <= apply;
      if (cfg_wr) begin
        sh_en_q  <= cfg_en;
        sh_off_q <= cfg_offset;
        sh_w_q   <= cfg_width;
        sh_h_q   <= cfg_height;
      end
      if (cfg_wr)     pend_q <= 1'b1;
      else if (apply) pend_q <= 1'b0;
      if (apply) begin
        en_q  <= sh_en_q;
        off_q <= sh_off_q;
        w_q   <= sh_w_q;
        h_q   <= sh_h_q;
      end
      if (err_set)     err_q <= 1'b1;
      else if (cfg_wr) err_q <= 1'b0;
    end
  end

  // Counters restart on every frame edge, which covers both SYNC->ACTIVE
  // and the aborted-frame restart inside ACTIVE.
  area_bin_coord_cnt #(
    .DIM_W (DIM_W)
  ) u_coord (
    .clk_i  (video_clk),
    .rst_ni (rst_n),
    .clr_i  (vs_rise),
    .de_i   (matrix_de),
    .x_o    (x),
    .y_o    (y)
  );

  assign last_px = (x == w_q - 1'b1) && (y == h_q - 1'b1);

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        busy_c = 1'b1;
        if (!en_q)        state_d = ST_IDLE;
        else if (vs_rise) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        busy_c = 1'b1;
        if (!vs_rise && matrix_de && last_px) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = en_q ? ST_SYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Border windows have incomplete 3x3 neighbourhoods; degenerate frames
  // (width or height under 3) have no interior at all.
  assign mask = (w_q < MIN_DIM) || (h_q < MIN_DIM) ||
                (x == '0) || (x >= w_q - 1'b1) ||
                (y == '0) || (y >= h_q - 1'b1);

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_pipe_q <= '0;
    end else begin
      mask_pipe_q[0] <= mask;
      for (int i = 1; i < PIPE_LAT; i++) mask_pipe_q[i] <= mask_pipe_q[i-1];
    end
  end

  assign mask_dly = mask_pipe_q[PIPE_LAT-1];

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vs_q   <= 1'b0;
      out_de_q   <= 1'b0;
      out_data_q <= 1'b0;
    end else begin
      out_vs_q   <= bin_vs;
      out_de_q   <= bin_de;
      out_data_q <= bin_data & ~mask_dly & en_q & bin_de;
    end
  end

`ifdef AREA_BIN_STAT_EN
  logic [FG_W-1:0] acc_q;
  logic [FG_W-1:0] fg_q;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      fg_q  <= '0;
    end else begin
      if (vs_rise) acc_q <= '0;
      else if ((state_q == ST_ACTIVE) && out_data_q && (acc_q != '1)) acc_q <= acc_q + 1'b1;
      if (state_q == ST_DONE) fg_q <= acc_q;
    end
  end

  assign fg_count = fg_q;
`else
  assign fg_count = '0;
`endif

  assign ctrl_en     = en_q;
  assign ctrl_offset = off_q;
  assign out_vs      = out_vs_q;
  assign out_de      = out_de_q;
  assign out_data    = out_data_q;
  assign cfg_ack     = ack_q;
  assign frame_done  = done_c;
  assign busy        = busy_c;
  assign frame_err   = err_q;

endmodule
